tile_line_fetcher: RTL and testbench



---
 rtl/tile_line_fetcher.sv | 179 +++++++++++++++++
 tb/tb_tile_line_fetcher.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_line_fetcher.sv
// -----------------------------------------------------------------------------
// tile_line_fetcher
//
// Background read engine for the tile/sprite display memories. A line_start
// command renders one 640-pixel scanline. For each of the 40 tiles on the line,
// the engine reads a tile index from the tile buffer and the tile's 16-pixel row
// word from tile graphics. It then reads the palette once per pixel. Each
// resulting 24-bit RGB pixel is streamed over a valid/ready handshake.
//
// Ports
//   clk                  system clock
//   reset                synchronous active-high reset
//   line_start, line_y   one-cycle render request and its scanline number (0..479)
//   busy                 high while a line is being rendered
//   line_done            one-cycle pulse after the final pixel handshake
//   addr_/data_tile_buffer     tile buffer read port (1-cycle latency)
//   addr_/data_tile_graphics   tile graphics read port (1-cycle latency)
//   addr_/data_color_palettes  palette read port (1-cycle latency)
//   pix_valid, pix_ready, pix_rgb  pixel stream to the downstream consumer
// -----------------------------------------------------------------------------
module tile_line_fetcher (
    input  logic        clk,
    input  logic        reset,
    input  logic        line_start,
    input  logic [8:0]  line_y,
    output logic        busy,
    output logic        line_done,
    output logic [8:0]  addr_tile_buffer,
    input  logic [31:0] data_tile_buffer,
    output logic [10:0] addr_tile_graphics,
    input  logic [31:0] data_tile_graphics,
    output logic [2:0]  addr_color_palettes,
    input  logic [23:0] data_color_palettes,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [23:0] pix_rgb
);

    typedef enum logic [2:0] {
        IDLE,
        TB_RD,
        TG_RD,
        ROW_LAT,
        PAL_RD,
        PIX_OUT
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [8:0]  y_q;          // scanline being rendered
    logic [5:0]  col;          // tile column 0..39
    logic [3:0]  px;           // pixel within the tile row 0..15
    logic        idx_hi;       // bit 7 of the tile index selects the palette half
    logic [31:0] row_word;     // 16 pixels x 2 bits for the current tile row
    logic        line_done_q;

    logic        start_ok;
    logic        handshake;
    logic        last_pixel;
    logic [8:0]  tb_word;
    logic [7:0]  tile_idx;
    logic [1:0]  pal_px;

    assign start_ok   = (state == IDLE) && line_start && (line_y < 9'd480);
    assign handshake  = (state == PIX_OUT) && pix_ready;
    assign last_pixel = (px == 4'd15) && (col == 6'd39);

    // Ten words per tile row; the largest address (row 29, word 9) is 299.
    assign tb_word  = ({4'b0, y_q[8:4]} * 9'd10) + {5'b0, col[5:2]};

    // Tile buffer data is valid in TG_RD; col is unchanged since TB_RD.
    assign tile_idx = data_tile_buffer[{col[1:0], 3'b000} +: 8];
    assign pal_px   = row_word[{px, 1'b0} +: 2];

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: every clocked register uses non-blocking assignments so all flops
    // sample the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: state_next gets a default before the case, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok) state_next = TB_RD;
            TB_RD:   state_next = TG_RD;
            TG_RD:   state_next = ROW_LAT;
            ROW_LAT: state_next = PAL_RD;
            PAL_RD:  state_next = PIX_OUT;
            PIX_OUT: begin
                if (pix_ready) begin
                    if (px != 4'd15)        state_next = PAL_RD;
                    else if (col != 6'd39)  state_next = TB_RD;
                    else                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            y_q         <= '0;
            col         <= '0;
            px          <= '0;
            idx_hi      <= 1'b0;
            row_word    <= '0;
            line_done_q <= 1'b0;
        end else begin
            line_done_q <= handshake && last_pixel;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        y_q <= line_y;
                        col <= '0;
                    end
                end
                TG_RD:   idx_hi <= tile_idx[7];
                ROW_LAT: begin
                    row_word <= data_tile_graphics;
                    px       <= '0;
                end
                PIX_OUT: begin
                    if (pix_ready) begin
                        if (px != 4'd15) begin
                            px <= px + 4'd1;
                        end else if (col != 6'd39) begin
                            col <= col + 6'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: each address is driven only in the state that owns the read,
    // and is zero otherwise. In PIX_OUT the palette address is held, so the
    // palette keeps returning the same pixel while the consumer stalls.
    // -------------------------------------------------------------------------
    always_comb begin
        addr_tile_buffer    = '0;
        addr_tile_graphics  = '0;
        addr_color_palettes = '0;
        pix_valid           = 1'b0;
        pix_rgb             = '0;
        case (state)
            TB_RD:   addr_tile_buffer   = tb_word;
            TG_RD:   addr_tile_graphics = {tile_idx[6:0], y_q[3:0]};
            PAL_RD:  addr_color_palettes = {idx_hi, pal_px};
            PIX_OUT: begin
                addr_color_palettes = {idx_hi, pal_px};
                pix_valid           = 1'b1;
                pix_rgb             = data_color_palettes;
            end
            default: ;
        endcase
    end

    assign busy      = (state != IDLE);
    assign line_done = line_done_q;

endmodule

// File: tb/tb_tile_line_fetcher.sv
module tb_tile_line_fetcher;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        line_start = 1'b0;
    logic [8:0]  line_y = '0;
    logic        busy;
    logic        line_done;
    logic [8:0]  addr_tile_buffer;
    logic [31:0] data_tile_buffer = '0;
    logic [10:0] addr_tile_graphics;
    logic [31:0] data_tile_graphics = '0;
    logic [2:0]  addr_color_palettes;
    logic [23:0] data_color_palettes = '0;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic [23:0] pix_rgb;

    tile_line_fetcher dut (
        .clk                 (clk),
        .reset               (reset),
        .line_start          (line_start),
        .line_y              (line_y),
        .busy                (busy),
        .line_done           (line_done),
        .addr_tile_buffer    (addr_tile_buffer),
        .data_tile_buffer    (data_tile_buffer),
        .addr_tile_graphics  (addr_tile_graphics),
        .data_tile_graphics  (data_tile_graphics),
        .addr_color_palettes (addr_color_palettes),
        .data_color_palettes (data_color_palettes),
        .pix_valid           (pix_valid),
        .pix_ready           (pix_ready),
        .pix_rgb             (pix_rgb)
    );

    always #5 clk = ~clk;

    // Memory models with 1-cycle read latency
    logic [31:0] tb_mem  [0:511];
    logic [31:0] tg_mem  [0:2047];
    logic [23:0] pal_mem [0:7];
    logic [23:0] cyc4    [0:3];

    always @(posedge clk) begin
        data_tile_buffer    <= tb_mem[addr_tile_buffer];
        data_tile_graphics  <= tg_mem[addr_tile_graphics];
        data_color_palettes <= pal_mem[addr_color_palettes];
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Results gathered by run_line
    int r_hs, r_bad, r_first_bad, r_done_cnt, r_done_cyc, r_first_valid;
    int r_unstable, r_busy_err, r_post_busy;
    logic r_rst_valid, r_rst_busy, r_chain_busy;
    int seen_tb [0:39];
    int seen_tg [0:39];
    int pal_min [0:39];
    int pal_max [0:39];

    function automatic logic [23:0] exp_pixel(input logic [8:0] y, input int n);
        int c;
        int p;
        logic [31:0] w;
        logic [7:0]  idx;
        logic [31:0] row;
        logic [1:0]  bits;
        c    = n / 16;
        p    = n % 16;
        w    = tb_mem[y[8:4] * 10 + c / 4];
        idx  = w[(c % 4) * 8 +: 8];
        row  = tg_mem[{idx[6:0], y[3:0]}];
        bits = row[p * 2 +: 2];
        return pal_mem[{idx[7], bits}];
    endfunction

    task automatic run_line(input logic [8:0] y, input bit rand_ready, input bit use_const,
                            input int restart_at, input int reset_at, input bit chain,
                            input logic [8:0] chain_y, input bit skip_start);
        bit          prev_valid;
        bit          prev_ready;
        logic [23:0] prev_rgb;
        logic [23:0] expv;
        int          c;
        r_hs = 0; r_bad = 0; r_first_bad = -1; r_done_cnt = 0; r_done_cyc = -1;
        r_first_valid = -1; r_unstable = 0; r_busy_err = 0; r_post_busy = 0;
        r_rst_valid = 1'bx; r_rst_busy = 1'bx; r_chain_busy = 1'bx;
        for (int i = 0; i < 40; i++) begin
            seen_tb[i] = -1; seen_tg[i] = -1; pal_min[i] = 8; pal_max[i] = -1;
        end
        if (!skip_start) begin
            @(negedge clk);
            line_start = 1'b1;
            line_y     = y;
            @(negedge clk);
            line_start = 1'b0;
        end
        prev_valid = 1'b0; prev_ready = 1'b0; prev_rgb = '0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            c = (r_hs / 16 > 39) ? 39 : r_hs / 16;
            if (r_done_cnt == 0) begin
                if (int'(addr_tile_buffer) > seen_tb[c])   seen_tb[c] = int'(addr_tile_buffer);
                if (int'(addr_tile_graphics) > seen_tg[c]) seen_tg[c] = int'(addr_tile_graphics);
                if (pix_valid === 1'b1) begin
                    if (int'(addr_color_palettes) < pal_min[c]) pal_min[c] = int'(addr_color_palettes);
                    if (int'(addr_color_palettes) > pal_max[c]) pal_max[c] = int'(addr_color_palettes);
                end
            end
            if (pix_valid === 1'b1 && r_first_valid < 0) r_first_valid = cyc;
            if (prev_valid && !prev_ready && (pix_valid !== 1'b1 || pix_rgb !== prev_rgb))
                r_unstable++;
            if (r_done_cnt == 0 && line_done !== 1'b1 && busy !== 1'b1) r_busy_err++;
            if (line_done === 1'b1) begin
                r_done_cnt++;
                r_done_cyc = cyc;
                if (busy !== 1'b0) r_busy_err++;
                if (chain) begin
                    line_start = 1'b1;
                    line_y     = chain_y;
                    @(negedge clk);
                    line_start   = 1'b0;
                    r_chain_busy = busy;
                    return;
                end
            end
            if (r_done_cnt > 0 && cyc >= r_done_cyc + 20) return;
            line_start = 1'b0;
            pix_ready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pix_valid === 1'b1 && pix_ready) begin
                expv = use_const ? cyc4[r_hs % 4] : exp_pixel(y, r_hs);
                if (r_hs >= 640 || pix_rgb !== expv) begin
                    if (r_bad == 0) r_first_bad = r_hs;
                    r_bad++;
                end
                r_hs++;
                if (r_hs == restart_at) begin
                    line_start = 1'b1;
                    line_y     = 9'd5;
                end
                if (r_hs == reset_at) begin
                    reset = 1'b1;
                    @(negedge clk);
                    r_rst_valid = pix_valid;
                    r_rst_busy  = busy;
                    reset     = 1'b0;
                    pix_ready = 1'b0;
                    for (int k = 0; k < 10; k++) begin
                        @(negedge clk);
                        if (line_done !== 1'b0) r_done_cnt++;
                        if (busy !== 1'b0) r_post_busy++;
                    end
                    return;
                end
            end
            prev_valid = (pix_valid === 1'b1);
            prev_ready = pix_ready;
            prev_rgb   = pix_rgb;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        n_checks++;
        if (line_done !== 1'b0) begin n_fail++; $display("FAIL reset_line_done: got %b, expected 0", line_done); end
        n_checks++;
        if (pix_valid !== 1'b0 || pix_rgb !== 24'h0) begin
            n_fail++; $display("FAIL reset_pixel: got valid=%b rgb=%h, expected 0/000000", pix_valid, pix_rgb);
        end
        n_checks++;
        if ({addr_tile_buffer, addr_tile_graphics, addr_color_palettes} !== 23'h0) begin
            n_fail++; $display("FAIL reset_addr: got %h/%h/%h, expected all 0",
                               addr_tile_buffer, addr_tile_graphics, addr_color_palettes);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_line();
        run_line(9'd0, 1'b0, 1'b1, -1, -1, 1'b0, 9'd0, 1'b0);
        n_checks++;
        if (r_first_valid !== 4) begin n_fail++; $display("FAIL basic_first_valid: got %0d, expected 4", r_first_valid); end
        n_checks++;
        if (r_hs !== 640) begin n_fail++; $display("FAIL basic_handshakes: got %0d, expected 640", r_hs); end
        n_checks++;
        if (r_bad !== 0) begin n_fail++; $display("FAIL basic_pixels: got %0d bad (first %0d), expected 0", r_bad, r_first_bad); end
        n_checks++;
        if (r_done_cnt !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d, expected 1", r_done_cnt); end
        n_checks++;
        if (r_done_cyc !== 1400) begin n_fail++; $display("FAIL basic_done_cycle: got %0d, expected 1400", r_done_cyc); end
        n_checks++;
        if (r_busy_err !== 0) begin n_fail++; $display("FAIL basic_busy: got %0d bad cycles, expected 0", r_busy_err); end
    endtask

    task automatic test_index_select();
        run_line(9'd21, 1'b0, 1'b0, -1, -1, 1'b0, 9'd0, 1'b0);
        n_checks++;
        if (seen_tb[38] !== 19) begin n_fail++; $display("FAIL idx_tb_addr_col38: got %0d, expected 19", seen_tb[38]); end
        n_checks++;
        if (seen_tg[38] !== 'h035) begin n_fail++; $display("FAIL idx_tg_addr_col38: got %0h, expected 35", seen_tg[38]); end
        n_checks++;
        if (pal_min[38] !== 4 || pal_max[38] !== 7) begin
            n_fail++; $display("FAIL idx_pal_range_col38: got %0d..%0d, expected 4..7", pal_min[38], pal_max[38]);
        end
        n_checks++;
        if (seen_tb[11] !== 12 || seen_tg[11] !== 'h035) begin
            n_fail++; $display("FAIL idx_col11: got tb=%0d tg=%0h, expected tb=12 tg=35", seen_tb[11], seen_tg[11]);
        end
        n_checks++;
        if (r_hs !== 640 || r_bad !== 0) begin
            n_fail++; $display("FAIL idx_pixels: got %0d handshakes %0d bad, expected 640 and 0", r_hs, r_bad);
        end
    endtask

    task automatic test_random_ready();
        run_line(9'd479, 1'b1, 1'b0, -1, -1, 1'b0, 9'd0, 1'b0);
        n_checks++;
        if (r_hs !== 640) begin n_fail++; $display("FAIL rand_handshakes: got %0d, expected 640", r_hs); end
        n_checks++;
        if (r_bad !== 0) begin n_fail++; $display("FAIL rand_pixels: got %0d bad (first %0d), expected 0", r_bad, r_first_bad); end
        n_checks++;
        if (r_unstable !== 0) begin n_fail++; $display("FAIL rand_stall_stable: got %0d changes, expected 0", r_unstable); end
        n_checks++;
        if (r_done_cnt !== 1) begin n_fail++; $display("FAIL rand_done_count: got %0d, expected 1", r_done_cnt); end
        n_checks++;
        if (seen_tb[39] !== 299) begin n_fail++; $display("FAIL rand_max_tb_addr: got %0d, expected 299", seen_tb[39]); end
    endtask

    task automatic test_invalid_y();
        logic [8:0] ys [0:1];
        int activity;
        ys[0] = 9'd480;
        ys[1] = 9'd511;
        pix_ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            activity = 0;
            @(negedge clk);
            line_start = 1'b1;
            line_y     = ys[j];
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                line_start = 1'b0;
                if (busy !== 1'b0 || pix_valid !== 1'b0 || line_done !== 1'b0 ||
                    {addr_tile_buffer, addr_tile_graphics, addr_color_palettes} !== 23'h0)
                    activity++;
            end
            n_checks++;
            if (activity !== 0) begin
                n_fail++; $display("FAIL invalid_y_%0d: got %0d active cycles, expected 0", ys[j], activity);
            end
        end
    endtask

    task automatic test_restart_and_reset();
        run_line(9'd200, 1'b0, 1'b0, 100, -1, 1'b0, 9'd0, 1'b0);
        n_checks++;
        if (r_hs !== 640 || r_bad !== 0) begin
            n_fail++; $display("FAIL restart_pixels: got %0d handshakes %0d bad, expected 640 and 0", r_hs, r_bad);
        end
        n_checks++;
        if (r_done_cnt !== 1 || r_done_cyc !== 1400) begin
            n_fail++; $display("FAIL restart_done: got count %0d cycle %0d, expected 1 at 1400", r_done_cnt, r_done_cyc);
        end
        run_line(9'd300, 1'b0, 1'b0, -1, 300, 1'b0, 9'd0, 1'b0);
        n_checks++;
        if (r_rst_valid !== 1'b0 || r_rst_busy !== 1'b0) begin
            n_fail++; $display("FAIL midline_reset: got valid=%b busy=%b, expected 0/0", r_rst_valid, r_rst_busy);
        end
        n_checks++;
        if (r_done_cnt !== 0 || r_post_busy !== 0) begin
            n_fail++; $display("FAIL midline_reset_quiet: got done=%0d busy=%0d, expected 0/0", r_done_cnt, r_post_busy);
        end
        run_line(9'd300, 1'b0, 1'b0, -1, -1, 1'b0, 9'd0, 1'b0);
        n_checks++;
        if (r_hs !== 640 || r_bad !== 0 || r_done_cnt !== 1) begin
            n_fail++; $display("FAIL after_reset_line: got %0d handshakes %0d bad %0d done, expected 640/0/1",
                               r_hs, r_bad, r_done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        run_line(9'd0, 1'b0, 1'b0, -1, -1, 1'b1, 9'd16, 1'b0);
        n_checks++;
        if (r_chain_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got busy=%b, expected 1", r_chain_busy); end
        run_line(9'd16, 1'b0, 1'b0, -1, -1, 1'b0, 9'd0, 1'b1);
        n_checks++;
        if (r_hs !== 640 || r_bad !== 0 || r_done_cyc !== 1400) begin
            n_fail++; $display("FAIL b2b_line: got %0d handshakes %0d bad done at %0d, expected 640/0/1400",
                               r_hs, r_bad, r_done_cyc);
        end
    endtask

    initial begin
        cyc4[0] = 24'h000000; cyc4[1] = 24'hFF0000; cyc4[2] = 24'h00FF00; cyc4[3] = 24'h0000FF;
        pal_mem[0] = 24'h000000; pal_mem[1] = 24'hFF0000; pal_mem[2] = 24'h00FF00; pal_mem[3] = 24'h0000FF;
        pal_mem[4] = 24'h101010; pal_mem[5] = 24'h808080; pal_mem[6] = 24'hFFFF00; pal_mem[7] = 24'h00FFFF;
        for (int i = 0; i < 2048; i++) tg_mem[i] = $urandom;
        tg_mem[0]      = 32'hE4E4E4E4;
        tg_mem[11'h035] = 32'h1B1B1B1B;
        for (int i = 0; i < 512; i++) tb_mem[i] = (i >= 10 && i < 300) ? $urandom : 32'h0;
        tb_mem[12] = 32'h83020100;
        tb_mem[19] = 32'h11834241;

        test_reset();
        test_basic_line();
        test_index_select();
        test_random_ready();
        test_invalid_y();
        test_restart_and_reset();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
